linreg_stream_accel: RTL and testbench
======================================

Name: linreg_stream_accel

Overview:
- Parametrised successor to the fixed 150-sample, 20-bit regression datapath.
- Accepts a stream of N unsigned (x, y) samples over a valid/ready handshake and accumulates Σx, Σy, Σxx and Σxy.
- Computes the least-squares line y = b0 + b1·x with a shared sequential restoring divider.
- Returns signed fixed-point, saturated b0 and b1 over an output valid/ready handshake. Sits between the sample source and the consumer of the coefficients.

Parameters:
- DW, 20, sample width; also the width of the b0 and b1 outputs.
- N, 150, samples per regression batch (N ≥ 2).
- FRAC, 10, fractional bits of b0 and b1 (two's complement Q(DW-FRAC).FRAC).

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- clr  in  1  synchronous abort: clears sums and count, returns to ACC.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- x  in  DW  unsigned sample x.
- y  in  DW  unsigned sample y.
- out_valid  out  1  b0 and b1 are valid.
- out_ready  in  1  consumer takes the result.
- b0  out  DW  intercept, signed Q format.
- b1  out  DW  slope, signed Q format.
- degen  out  1  denominator was zero; b1 is forced to 0.
- sat  out  1  b0 or b1 was saturated.
- busy  out  1  state is not ACC.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = ACC; sums and count = 0.
  - in_ready = 1; out_valid = 0; b0 = b1 = 0; degen = sat = 0.
- Accumulator widths:
  - CW = clog2(N+1).
  - Σx and Σy: DW+CW bits.
  - Σxx and Σxy: 2DW+CW bits.
  - Sums are unsigned and exact; they never overflow.
- States:
  - ACC:
    - in_ready = 1.
    - Accept on in_valid & in_ready: add x, y, x·x and x·y into the sums; cnt++.
    - On the accept that makes cnt = N, go to CALC1.
  - CALC1: register the products N·Σxy, Σx·Σy, N·Σxx and Σx·Σx.
  - CALC2:
    - NUM = (N·Σxy − Σx·Σy) << FRAC, signed.
    - DEN = N·Σxx − (Σx)², which is always ≥ 0.
    - If DEN = 0, set degen and skip the b1 division; the quotient is 0.
  - DIV1:
    - NUM / DEN on the divider, DIVW cycles.
    - DIVW = 2DW + 2CW + FRAC + 2.
    - Divide magnitudes, then apply the sign. The result truncates toward zero.
  - B0P:
    - b1s = b1 quotient saturated to DW signed bits.
    - NUM0 = (Σy << FRAC) − b1s·Σx.
  - DIV2:
    - NUM0 / N, DIVW cycles, truncate toward zero.
    - Saturate to DW signed bits.
  - DONE:
    - out_valid = 1; b0, b1, degen and sat held stable.
    - Leave on out_valid & out_ready: clear sums and count, go to ACC.
    - Outputs keep their last value until the next DONE.
- Latency:
  - out_valid rises exactly 2·DIVW + 3 rising edges after the edge that accepts sample N.
  - When degen is set, latency is unchanged: DIV1 still runs its DIVW idle cycles.
- Saturation: clamp to [−2^(DW−1), 2^(DW−1)−1] and set sat. sat is the OR over b0 and b1.
- in_ready = 0 in every state except ACC; samples offered in other states are neither accepted nor lost.
- clr:
  - Has priority over everything except rst, in any state.
  - Takes effect next cycle: state ACC, sums and count 0, out_valid 0.
  - b0, b1, degen and sat keep their last values.
- Simultaneous events:
  - In DONE, out_ready and a new in_valid in the same cycle: the sample is not accepted (in_ready = 0). It is accepted on the following cycle in ACC.
- rst deassertion mid-batch: the partial batch is discarded.

Decomposition:
- Package linreg_pkg:
  - State enum: ACC, CALC1, CALC2, DIV1, B0P, DIV2, DONE.
  - Functions clog2 and the width constants CW and DIVW.
  - Function sat_signed(value, DW).
- Sub-module seq_div:
  - Parameter W.
  - Ports: start, dividend, divisor (unsigned).
  - Outputs: quotient, done.
  - One quotient bit per cycle; done asserts W cycles after start.
  - Instantiated once and reused by DIV1 and DIV2.
- The top level handles signs, saturation and the FSM.

Test Plan (DW=8, N=4, FRAC=4 unless noted):
- Exact line: (x,y) = (1,3), (2,5), (3,7), (4,9) → b1=32 (2.0), b0=16 (1.0), degen=0, sat=0. out_valid exactly 2·DIVW+3 edges after the 4th accept.
- Truncation: (0,0), (1,0), (2,0), (3,1) → b1=4 (0.25, the true value 0.3 truncated), b0=−2 (0xFE).
- Degenerate: x=5 for all samples, y=1..4 → degen=1, b1=0, b0=40 (2.5), sat=0.
- Saturation: (0,10), (1,9), (2,8), (3,7) → b1=−16 (0xF0); b0 is clamped from 160 to 127, sat=1.
- Handshake:
  - in_valid held high during the compute phase: no samples are accepted (in_ready = 0).
  - out_ready held low for 5 cycles: outputs remain stable.
  - On release, ACC is re-entered, and the next batch's results are independent of the previous batch.
- Abort and reset:
  - clr after 2 samples, then a full exact-line batch: results equal scenario 1.
  - rst pulsed low during DIV1: all outputs 0 immediately; no out_valid appears for the aborted batch.
  - Default parameters (DW=20, N=150) with y=x: b1=1024, b0=0.

Source files
------------

// File: rtl/linreg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : linreg_pkg                                                   |
// | Description : Shared state encoding, width helpers and signed saturation  |
// |               for the streaming least-squares regression accelerator.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package linreg_pkg;

    // Widest intermediate the saturation helper can accept
    localparam int WIDEW = 128;

    typedef enum logic [2:0] {
        ST_ACC   = 3'd0,
        ST_CALC1 = 3'd1,
        ST_CALC2 = 3'd2,
        ST_DIV1  = 3'd3,
        ST_B0P   = 3'd4,
        ST_DIV2  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Smallest r with 2**r >= value
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Sample counter width: must hold the value N itself
    function automatic int calc_cw(input int n);
        return clog2(n + 1);
    endfunction

    // Divider width: covers |NUM| << FRAC plus sign headroom
    function automatic int calc_divw(input int dw, input int n, input int frac);
        return 2*dw + 2*calc_cw(n) + frac + 2;
    endfunction

    // Clamp a signed value into the dw-bit two's complement range
    function automatic logic signed [WIDEW-1:0] sat_signed(
        input logic signed [WIDEW-1:0] value,
        input int                      dw
    );
        logic signed [WIDEW-1:0] hi;
        logic signed [WIDEW-1:0] lo;
        hi = (WIDEW'(1) <<< (dw - 1)) - WIDEW'(1);
        lo = -(WIDEW'(1) <<< (dw - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/linreg_stream_accel_seq_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_div                                                      |
// | Description : Unsigned restoring divider, one quotient bit per cycle. The  |
// |               first bit is resolved on the start edge, so the quotient is  |
// |               final (done pulses) W cycles after the start cycle.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_div
    import linreg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CNTW = clog2(W + 1);

    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    logic [W-1:0]    src_rem;
    logic [W-1:0]    src_quo;
    logic [W-1:0]    src_dvs;
    logic [W:0]      trial;

    // One restoring step per cycle; a start reloads operands and takes the first step
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        trial   = {src_rem, src_quo[W-1]};
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (start || (cnt_q != '0)) begin
            if (trial >= {1'b0, src_dvs}) begin
                rem_d = W'(trial - {1'b0, src_dvs});
                quo_d = {src_quo[W-2:0], 1'b1};
            end else begin
                rem_d = trial[W-1:0];
                quo_d = {src_quo[W-2:0], 1'b0};
            end
            dvs_d  = src_dvs;
            cnt_d  = start ? CNTW'(W - 1) : cnt_q - CNTW'(1);
            done_d = start ? (W == 1) : (cnt_q == CNTW'(1));
        end
    end

    // Divider state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: rtl/linreg_stream_accel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : linreg_stream_accel                                          |
// | Description : Streams N unsigned (x,y) samples, accumulates the moments   |
// |               and returns saturated Q-format least-squares b0 and b1.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module linreg_stream_accel
    import linreg_pkg::*;
#(
    parameter int DW   = 20,
    parameter int N    = 150,
    parameter int FRAC = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] b0,
    output logic [DW-1:0] b1,
    output logic          degen,
    output logic          sat,
    output logic          busy
);
    localparam int CW   = calc_cw(N);
    localparam int DIVW = calc_divw(DW, N, FRAC);
    localparam int SW   = DIVW + 1;
    localparam int SXW  = DW + CW;
    localparam int SQW  = 2*DW + CW;
    localparam int PW   = 2*DW + 2*CW;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SXW-1:0]        sx_q, sx_d, sy_q, sy_d;
    logic [SQW-1:0]        sxx_q, sxx_d, sxy_q, sxy_d;
    logic [PW-1:0]         p_nsxy_q, p_nsxy_d, p_sxsy_q, p_sxsy_d;
    logic [PW-1:0]         p_nsxx_q, p_nsxx_d, p_sxsx_q, p_sxsx_d;
    logic                  neg_q, neg_d;
    logic                  degw_q, degw_d;
    logic                  sat1_q, sat1_d;
    logic signed [DW-1:0]  b1w_q, b1w_d;
    logic [DW-1:0]         b0_q, b0_d, b1_q, b1_d;
    logic                  degen_q, degen_d, sat_q, sat_d, out_valid_q, out_valid_d;

    logic [2*DW-1:0]       xx, xy;
    logic signed [SW-1:0]  num, num0, q_signed;
    logic [PW-1:0]         den;
    logic signed [DW-1:0]  res_sat, b1s;
    logic                  res_clamped;
    logic                  div_start, div_done;
    logic [DIVW-1:0]       div_dividend, div_divisor, div_quotient;

    seq_div #(.W(DIVW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

    // Datapath: sample products, numerators, signed quotient and its saturation
    always_comb begin
        xx       = {{DW{1'b0}}, x} * {{DW{1'b0}}, x};
        xy       = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        num      = (signed'(SW'(p_nsxy_q)) - signed'(SW'(p_sxsy_q))) <<< FRAC;
        den      = p_nsxx_q - p_sxsx_q;
        q_signed = signed'({1'b0, div_quotient});
        if (neg_q) q_signed = -q_signed;
        res_sat     = DW'(sat_signed(WIDEW'(q_signed), DW));
        res_clamped = (SW'(res_sat) != q_signed);
        // A degenerate batch has slope 0 regardless of what the divider produced
        b1s      = degw_q ? '0 : res_sat;
        num0     = (signed'(SW'(sy_q)) <<< FRAC) - SW'(b1s) * signed'(SW'(sx_q));
    end

    // Divider operand selection: magnitudes in, sign re-applied on the way out
    always_comb begin
        div_start    = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        if (state_q == ST_CALC2) begin
            div_start    = !clr;
            div_dividend = DIVW'(num[SW-1] ? -num : num);
            div_divisor  = DIVW'(den);
        end else if (state_q == ST_B0P) begin
            div_start    = !clr;
            div_dividend = DIVW'(num0[SW-1] ? -num0 : num0);
            div_divisor  = DIVW'(N);
        end
    end

    // Next-state and register update logic for the batch sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        sxx_d       = sxx_q;
        sxy_d       = sxy_q;
        p_nsxy_d    = p_nsxy_q;
        p_sxsy_d    = p_sxsy_q;
        p_nsxx_d    = p_nsxx_q;
        p_sxsx_d    = p_sxsx_q;
        neg_d       = neg_q;
        degw_d      = degw_q;
        sat1_d      = sat1_q;
        b1w_d       = b1w_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        degen_d     = degen_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    sx_d  = sx_q + SXW'(x);
                    sy_d  = sy_q + SXW'(y);
                    sxx_d = sxx_q + SQW'(xx);
                    sxy_d = sxy_q + SQW'(xy);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) state_d = ST_CALC1;
                end
            end
            ST_CALC1: begin
                p_nsxy_d = PW'(N) * PW'(sxy_q);
                p_sxsy_d = PW'(sx_q) * PW'(sy_q);
                p_nsxx_d = PW'(N) * PW'(sxx_q);
                p_sxsx_d = PW'(sx_q) * PW'(sx_q);
                state_d  = ST_CALC2;
            end
            ST_CALC2: begin
                degw_d  = (den == '0);
                neg_d   = num[SW-1];
                state_d = ST_DIV1;
            end
            ST_DIV1: begin
                if (div_done) state_d = ST_B0P;
            end
            ST_B0P: begin
                b1w_d   = b1s;
                sat1_d  = !degw_q && res_clamped;
                neg_d   = num0[SW-1];
                state_d = ST_DIV2;
            end
            ST_DIV2: begin
                if (div_done) begin
                    b0_d        = res_sat;
                    b1_d        = b1w_q;
                    degen_d     = degw_q;
                    sat_d       = sat1_q | res_clamped;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    sx_d        = '0;
                    sy_d        = '0;
                    sxx_d       = '0;
                    sxy_d       = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
        // Abort keeps the previous result visible but discards the batch
        if (clr) begin
            state_d     = ST_ACC;
            sx_d        = '0;
            sy_d        = '0;
            sxx_d       = '0;
            sxy_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    // All block state, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            sxx_q       <= '0;
            sxy_q       <= '0;
            p_nsxy_q    <= '0;
            p_sxsy_q    <= '0;
            p_nsxx_q    <= '0;
            p_sxsx_q    <= '0;
            neg_q       <= 1'b0;
            degw_q      <= 1'b0;
            sat1_q      <= 1'b0;
            b1w_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            degen_q     <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            sxx_q       <= sxx_d;
            sxy_q       <= sxy_d;
            p_nsxy_q    <= p_nsxy_d;
            p_sxsy_q    <= p_sxsy_d;
            p_nsxx_q    <= p_nsxx_d;
            p_sxsx_q    <= p_sxsx_d;
            neg_q       <= neg_d;
            degw_q      <= degw_d;
            sat1_q      <= sat1_d;
            b1w_q       <= b1w_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            degen_q     <= degen_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign busy      = (state_q != ST_ACC);
    assign out_valid = out_valid_q;
    assign b0        = b0_q;
    assign b1        = b1_q;
    assign degen     = degen_q;
    assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_linreg_stream_accel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_linreg_stream_accel                                       |
// | Description : Randomised self-checking bench with an arithmetic reference  |
// |               model of the least-squares fit (small and default configs). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_linreg_stream_accel;

    localparam int ADW   = 8;
    localparam int AN    = 4;
    localparam int AFRAC = 4;
    localparam int ADIVW = 2*ADW + 2*3 + AFRAC + 2;   // CW = 3 for N = 4
    localparam int ALAT  = 2*ADIVW + 3;
    localparam int BDW   = 20;
    localparam int BN    = 150;
    localparam int BDIVW = 2*BDW + 2*8 + 10 + 2;      // CW = 8 for N = 150
    localparam int BLAT  = 2*BDIVW + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            rst, clr;
    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [ADW-1:0]  a_x, a_y, a_b0, a_b1;
    logic            a_degen, a_sat, a_busy;
    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [BDW-1:0]  b_x, b_y, b_b0, b_b1;
    logic            b_degen, b_sat, b_busy;

    linreg_stream_accel #(.DW(ADW), .N(AN), .FRAC(AFRAC)) u_dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .x(a_x), .y(a_y),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .b0(a_b0), .b1(a_b1), .degen(a_degen), .sat(a_sat), .busy(a_busy)
    );

    linreg_stream_accel u_dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x), .y(b_y),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .b0(b_b0), .b1(b_b1), .degen(b_degen), .sat(b_sat), .busy(b_busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int acc_cyc = 0;
    int bx[AN];
    int by[AN];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clamp_q(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (ADW - 1)) - 1;
        lo = -(longint'(1) <<< (ADW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference: closed-form least squares on the current bx/by batch
    task automatic model_a(output longint e_b0, output longint e_b1,
                           output longint e_deg, output longint e_sat);
        longint sx, sy, sxx, sxy, num, den, q1, b1s, num0, q0;
        sx = 0; sy = 0; sxx = 0; sxy = 0;
        for (int i = 0; i < AN; i++) begin
            sx  += longint'(bx[i]);
            sy  += longint'(by[i]);
            sxx += longint'(bx[i]) * longint'(bx[i]);
            sxy += longint'(bx[i]) * longint'(by[i]);
        end
        num = (AN * sxy - sx * sy) * (longint'(1) <<< AFRAC);
        den = AN * sxx - sx * sx;
        if (den == 0) begin
            e_deg = 1;
            q1 = 0;
        end else begin
            e_deg = 0;
            q1 = num / den;
        end
        b1s   = clamp_q(q1);
        num0  = sy * (longint'(1) <<< AFRAC) - b1s * sx;
        q0    = num0 / AN;
        e_b1  = b1s;
        e_b0  = clamp_q(q0);
        e_sat = ((b1s != q1) || (e_b0 != q0)) ? 1 : 0;
    endtask

    task automatic send_a(input int xv, input int yv);
        int  w;
        bit  rdy;
        a_x = ADW'(xv);
        a_y = ADW'(yv);
        a_in_valid = 1'b1;
        w = 0;
        forever begin
            rdy = a_in_ready;
            @(posedge clk);
            if (rdy) break;
            @(negedge clk);
            w++;
            if (w > 200) begin
                check("send_timeout", w, 0);
                break;
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic run_batch(input string tag, input bit hold, input int stall);
        longint e_b0, e_b1, e_deg, e_sat;
        int n, extra;
        logic [ADW-1:0] s_b0, s_b1;
        model_a(e_b0, e_b1, e_deg, e_sat);
        for (int i = 0; i < AN; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_a(bx[i], by[i]);
        end
        if (hold) begin
            a_x = ADW'($urandom);
            a_y = ADW'($urandom);
            a_in_valid = 1'b1;
        end
        n = 0;
        extra = 0;
        while (a_out_valid !== 1'b1 && n < ALAT + 20) begin
            if (a_in_ready) extra++;
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_latency", tag), cyc - acc_cyc, ALAT);
        check($sformatf("%s_ready_in_compute", tag), extra, 0);
        check($sformatf("%s_b1", tag), longint'($signed(a_b1)), e_b1);
        check($sformatf("%s_b0", tag), longint'($signed(a_b0)), e_b0);
        check($sformatf("%s_degen", tag), longint'(a_degen), e_deg);
        check($sformatf("%s_sat", tag), longint'(a_sat), e_sat);
        check($sformatf("%s_ready_in_done", tag), longint'(a_in_ready), 0);
        s_b0 = a_b0;
        s_b1 = a_b1;
        repeat (stall) @(negedge clk);
        if (stall > 0) begin
            check($sformatf("%s_stall_valid", tag), longint'(a_out_valid), 1);
            check($sformatf("%s_stall_b0", tag), longint'(a_b0), longint'(s_b0));
            check($sformatf("%s_stall_b1", tag), longint'(a_b1), longint'(s_b1));
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check($sformatf("%s_release_valid", tag), longint'(a_out_valid), 0);
        check($sformatf("%s_release_busy", tag), longint'(a_busy), 0);
    endtask

    task automatic set_batch(input int x0, y0, x1, y1, x2, y2, x3, y3);
        bx[0] = x0; by[0] = y0; bx[1] = x1; by[1] = y1;
        bx[2] = x2; by[2] = y2; bx[3] = x3; by[3] = y3;
    endtask

    task automatic rand_batch();
        int mode;
        mode = int'($urandom_range(0, 2));
        for (int i = 0; i < AN; i++) begin
            case (mode)
                0:       begin bx[i] = int'($urandom_range(0, 255)); by[i] = int'($urandom_range(0, 255)); end
                1:       begin bx[i] = int'($urandom_range(0, 15));  by[i] = int'($urandom_range(0, 15));  end
                default: begin bx[i] = int'($urandom_range(0, 15));  by[i] = int'($urandom_range(0, 255)); end
            endcase
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, seen, nrdy;
        logic [ADW-1:0] p_b0, p_b1;
        logic [BDW-1:0] bv;
        rst = 1'b0; clr = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_x = '0; a_y = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_x = '0; b_y = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", longint'(a_in_ready), 1);
        check("reset_out_valid", longint'(a_out_valid), 0);
        check("reset_b0", longint'(a_b0), 0);
        check("reset_b1", longint'(a_b1), 0);
        check("reset_degen_sat", longint'({a_degen, a_sat}), 0);
        check("reset_busy", longint'(a_busy), 0);
        rst = 1'b1;
        @(negedge clk);

        set_batch(1, 3, 2, 5, 3, 7, 4, 9);  run_batch("exact", 1'b0, 0);
        set_batch(0, 0, 1, 0, 2, 0, 3, 1);  run_batch("trunc", 1'b0, 0);
        set_batch(5, 1, 5, 2, 5, 3, 5, 4);  run_batch("degen", 1'b0, 0);
        set_batch(0, 10, 1, 9, 2, 8, 3, 7); run_batch("satur", 1'b0, 0);
        set_batch(1, 3, 2, 5, 3, 7, 4, 9);  run_batch("hold", 1'b1, 5);

        // Abort after two samples, then a clean batch
        send_a(7, 200);
        send_a(100, 3);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy", longint'(a_busy), 0);
        set_batch(1, 3, 2, 5, 3, 7, 4, 9);  run_batch("after_clr", 1'b0, 0);

        // Abort in the middle of the slope division
        p_b0 = a_b0;
        p_b1 = a_b1;
        rand_batch();
        for (int i = 0; i < AN; i++) send_a(bx[i], by[i]);
        repeat (10) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_div_busy", longint'(a_busy), 0);
        check("clr_div_keep_b0", longint'(a_b0), longint'(p_b0));
        check("clr_div_keep_b1", longint'(a_b1), longint'(p_b1));
        seen = 0;
        repeat (ALAT + 10) begin
            if (a_out_valid) seen++;
            @(negedge clk);
        end
        check("clr_div_no_valid", seen, 0);

        for (int k = 0; k < 20; k++) begin
            rand_batch();
            run_batch($sformatf("rand%0d", k), ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while dividing
        set_batch(1, 3, 2, 5, 3, 7, 4, 9);
        for (int i = 0; i < AN; i++) send_a(bx[i], by[i]);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_b0", longint'(a_b0), 0);
        check("rst_mid_b1", longint'(a_b1), 0);
        check("rst_mid_flags", longint'({a_out_valid, a_degen, a_sat, a_busy}), 0);
        check("rst_mid_in_ready", longint'(a_in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (ALAT + 10) begin
            if (a_out_valid) seen++;
            @(negedge clk);
        end
        check("rst_mid_no_valid", seen, 0);
        set_batch(0, 10, 1, 9, 2, 8, 3, 7); run_batch("after_rst", 1'b0, 0);

        // Default configuration with y = x: slope exactly 1.0, intercept 0
        nrdy = 0;
        for (int i = 0; i < BN; i++) begin
            bv = BDW'($urandom_range(0, 20'hFFFFF));
            b_x = bv;
            b_y = bv;
            b_in_valid = 1'b1;
            if (!b_in_ready) nrdy++;
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        acc_cyc = cyc;
        check("dflt_ready", nrdy, 0);
        n = 0;
        while (b_out_valid !== 1'b1 && n < BLAT + 40) begin
            @(negedge clk);
            n++;
        end
        check("dflt_latency", cyc - acc_cyc, BLAT);
        check("dflt_b1", longint'($signed(b_b1)), 1024);
        check("dflt_b0", longint'($signed(b_b0)), 0);
        check("dflt_flags", longint'({b_degen, b_sat}), 0);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("dflt_release", longint'(b_out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
